jtag_master: RTL and testbench

- Host-side JTAG driver. Generates TCK/TMS/TDI from the system clock and samples TDO, driving the on-chip debug TAP (4-bit IR, IDCODE/BYPASS/BSR data registers) from a simple command/response interface.
- Sits between a host command source (UART/CPU bridge) and the TAP pins.
- Sequences all TAP state transitions itself. The host requests only reset, IR scan or DR scan.

---
 rtl/jtag_master.sv | 144 ++++++++++++++
 tb/tb_jtag_master.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_master.sv
// Host-side JTAG driver: turns reset / IR-scan / DR-scan commands into TCK/TMS/TDI
// sequences and collects TDO, always returning the TAP to Run-Test/Idle.
module jtag_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [4:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [1:0] T_RESET = 2'b00;
  localparam logic [1:0] T_IR    = 2'b01;
  localparam logic [1:0] T_DR    = 2'b10;
  localparam logic [1:0] T_RSVD  = 2'b11;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_PRE, S_SHIFT, S_POST, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [DW-1:0]      r_div;
  logic [4:0]         r_step, r_len, w_last_idx, w_nstep;
  logic [1:0]         r_type;
  logic [MAX_LEN-1:0] r_data, r_rsp, r_rsp_out;
  logic               r_tck, r_tms, r_tdi;
  logic               w_active, w_rise, w_fall, w_last, w_accept;

  // TMS value to present during period 'step' of state 's'
  function automatic logic f_tms(state_t s, logic [1:0] t, logic [4:0] step, logic [4:0] len);
    logic v;
    v = 1'b0;
    case (s)
      S_INIT:  v = (step != 5'd5);
      S_PRE: begin
        case (t)
          T_DR:    v = (step == 5'd0);
          T_IR:    v = (step < 5'd2);
          default: v = (step != 5'd5);
        endcase
      end
      S_SHIFT: v = (step == len);
      S_POST:  v = (step == 5'd0);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  assign w_active = (r_state == S_INIT) || (r_state == S_PRE) ||
                    (r_state == S_SHIFT) || (r_state == S_POST);
  assign w_rise   = w_active && (r_div == DW'(CLK_DIV - 1));
  assign w_fall   = w_active && (r_div == DW'(2 * CLK_DIV - 1));
  assign w_accept = (r_state == S_IDLE) && cmd_valid;
  assign w_last   = (r_step == w_last_idx);

  always_comb begin
    w_last_idx = 5'd0;
    case (r_state)
      S_INIT:  w_last_idx = 5'd5;
      S_PRE:   w_last_idx = (r_type == T_DR) ? 5'd2 : (r_type == T_IR) ? 5'd3 : 5'd5;
      S_SHIFT: w_last_idx = r_len;
      S_POST:  w_last_idx = 5'd1;
      default: w_last_idx = 5'd0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT:  if (w_fall && w_last) w_state_next = S_IDLE;
      S_IDLE:  if (cmd_valid) w_state_next = (cmd_type == T_RSVD) ? S_DONE : S_PRE;
      S_PRE:   if (w_fall && w_last) w_state_next = (r_type == T_RESET) ? S_DONE : S_SHIFT;
      S_SHIFT: if (w_fall && w_last) w_state_next = S_POST;
      S_POST:  if (w_fall && w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_INIT;
    endcase
  end

  assign w_nstep = (w_state_next != r_state) ? 5'd0 : r_step + 5'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_INIT;
      r_div     <= '0;
      r_step    <= '0;
      r_type    <= '0;
      r_len     <= '0;
      r_data    <= '0;
      r_rsp     <= '0;
      r_rsp_out <= '0;
      r_tck     <= 1'b0;
      r_tms     <= 1'b1;
      r_tdi     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_type <= cmd_type;
        r_len  <= cmd_len;
        r_data <= cmd_data;
        r_rsp  <= '0;
        r_div  <= '0;
        r_step <= '0;
        // every scan sequence starts with TMS=1 in its first low phase
        if (cmd_type != T_RSVD) r_tms <= 1'b1;
      end else if (w_active) begin
        r_div <= w_fall ? '0 : r_div + 1'b1;
        if (w_rise) begin
          r_tck <= 1'b1;
          if (r_state == S_SHIFT) r_rsp[r_step] <= TDO;
        end
        // the TCK falling edge is the only place TMS/TDI move
        if (w_fall) begin
          r_tck  <= 1'b0;
          r_step <= w_nstep;
          r_tms  <= f_tms(w_state_next, r_type, w_nstep, r_len);
          r_tdi  <= (w_state_next == S_SHIFT) ? r_data[w_nstep] : 1'b0;
        end
      end
      if ((w_state_next == S_DONE) && (r_state != S_DONE))
        r_rsp_out <= w_accept ? '0 : r_rsp;
    end
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    rsp_valid = (r_state == S_DONE);
  end

  assign TCK      = r_tck;
  assign TMS      = r_tms;
  assign TDI      = r_tdi;
  assign rsp_data = r_rsp_out;
endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: drives commands against a behavioural 4-bit-IR TAP and
// checks responses, latency, TCK counts and the TMS/TDI sequence of every scan.
`timescale 1ns/1ps
module tb_jtag_master;
  localparam int CLK_DIV = 4;
  localparam int MAX_LEN = 32;
  localparam logic [31:0] IDCODE_VAL = 32'hDEAD104D;
  localparam logic [3:0]  IR_IDCODE = 4'h1;
  localparam logic [3:0]  IR_BSR    = 4'h2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_type = 2'b00;
  logic [4:0]  cmd_len = 5'd0;
  logic [31:0] cmd_data = 32'h0;
  logic        cmd_ready, rsp_valid, busy, TCK, TMS, TDI, TDO;
  logic [31:0] rsp_data;

  always #5 CLK = ~CLK;

  jtag_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  // ---------------- behavioural TAP ----------------
  typedef enum logic [3:0] {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                            SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
  tap_t        ts = TLR;
  logic [3:0]  ir = IR_IDCODE;
  logic [3:0]  ir_sr = 4'h0;
  logic [31:0] dr_sr = 32'h0;
  logic        tdo_r = 1'b0;
  assign TDO = tdo_r;

  function automatic tap_t tap_next(tap_t s, logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDR  : RTI;
      SDR:  return m ? SIR  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDR  : RTI;
      SIR:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      default: return m ? SDR : RTI;
    endcase
  endfunction

  function automatic logic [31:0] shift_dr(logic [31:0] sr, logic din, logic [3:0] instr);
    logic [31:0] r;
    int len;
    len = (instr == IR_IDCODE) ? 32 : (instr == IR_BSR) ? 8 : 1;
    r = sr >> 1;
    r[len-1] = din;
    return r;
  endfunction

  always @(posedge TCK) begin
    case (ts)
      CDR:  dr_sr <= (ir == IR_IDCODE) ? IDCODE_VAL : (ir == IR_BSR) ? 32'hC3 : 32'h0;
      SHDR: dr_sr <= shift_dr(dr_sr, TDI, ir);
      CIR:  ir_sr <= 4'b0001;
      SHIR: ir_sr <= {TDI, ir_sr[3:1]};
      UIR:  ir <= ir_sr;
      TLR:  ir <= IR_IDCODE;
      default: ;
    endcase
    ts <= tap_next(ts, TMS);
  end

  always @(negedge TCK)
    tdo_r <= (ts == SHDR) ? dr_sr[0] : (ts == SHIR) ? ir_sr[0] : 1'b0;

  // ---------------- pin monitor ----------------
  int   rise_cnt = 0, viol = 0, phase_err = 0, hi_len = 0;
  logic p_tck = 1'b0, p_tms = 1'b1, p_tdi = 1'b0;
  bit   tms_hist [4096];
  bit   tdi_hist [4096];

  always @(negedge CLK) begin
    if (!RST_N) begin
      hi_len <= 0;
    end else begin
      if (TCK && (TMS != p_tms || TDI != p_tdi)) viol <= viol + 1;
      if (TCK && !p_tck && rise_cnt < 4096) begin
        tms_hist[rise_cnt] <= TMS;
        tdi_hist[rise_cnt] <= TDI;
        rise_cnt <= rise_cnt + 1;
      end
      if (TCK) hi_len <= hi_len + 1;
      else begin
        if (p_tck && hi_len != CLK_DIV) phase_err <= phase_err + 1;
        hi_len <= 0;
      end
    end
    p_tck <= TCK;
    p_tms <= TMS;
    p_tdi <= TDI;
  end

  // ---------------- checking helpers ----------------
  int tests_run = 0, tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected TMS/TDI at each TCK rising edge for one command (bit i = period i)
  function automatic void exp_wave(input logic [1:0] t, input logic [4:0] len, input logic [31:0] d,
                                   output logic [63:0] tms, output logic [63:0] tdi, output int n);
    tms = '0;
    tdi = '0;
    n = 0;
    if (t == 2'b11) return;
    if (t == 2'b00) begin
      tms[4:0] = 5'b11111;
      n = 6;
      return;
    end
    if (t == 2'b10) begin
      tms[0] = 1'b1;
      n = 3;
    end else begin
      tms[1:0] = 2'b11;
      n = 4;
    end
    for (int i = 0; i <= int'(len); i++) begin
      tdi[n] = d[i];
      tms[n] = (i == int'(len));
      n++;
    end
    tms[n] = 1'b1;
    n += 2;
  endfunction

  task automatic wait_ready(input string name);
    int cyc;
    cyc = 0;
    while (!cmd_ready && cyc < 500) begin
      @(negedge CLK);
      cyc++;
    end
    check({name, "_ready"}, cmd_ready, 1);
  endtask

  task automatic run_cmd(input string name, input logic [1:0] t, input logic [4:0] len,
                         input logic [31:0] d, input logic [31:0] exp_rsp, input int exp_per);
    int cyc, base, n;
    logic [63:0] et, ed, at, ad;
    wait_ready(name);
    base = rise_cnt;
    cmd_type = t;
    cmd_len = len;
    cmd_data = d;
    cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    cyc = 1;
    check({name, "_busy"}, {busy, cmd_ready}, 2'b10);
    while (!rsp_valid && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
    end
    check({name, "_done"}, rsp_valid, 1);
    check({name, "_rsp"}, rsp_data, exp_rsp);
    check({name, "_lat"}, cyc, 2 * CLK_DIV * exp_per + 1);
    check({name, "_tck"}, rise_cnt - base, exp_per);
    exp_wave(t, len, d, et, ed, n);
    at = '0;
    ad = '0;
    for (int i = 0; i < n && i < 64; i++) begin
      at[i] = tms_hist[base + i];
      ad[i] = tdi_hist[base + i];
    end
    check({name, "_tms"}, at, et);
    check({name, "_tdi"}, ad, ed);
    $display("[TB] %s type=%0d len=%0d data=%h -> rsp=%h latency=%0d clk", name, t, len, d, rsp_data, cyc);
    @(negedge CLK);
    check({name, "_hold"}, {rsp_valid, rsp_data}, {1'b0, exp_rsp});
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [4:0]  len;
    logic [31:0] d;
    logic [31:0] rsp;
    int          per;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, bad, cyc, pulses;
    logic [63:0] at;

    vecs[0] = '{2'b10, 5'd31, 32'h0000_0000, 32'hDEAD104D, 37};  // IDCODE
    vecs[1] = '{2'b01, 5'd3,  32'h0000_000F, 32'h0000_0001, 10}; // IR <- BYPASS
    vecs[2] = '{2'b10, 5'd7,  32'h0000_00A5, 32'h0000_004A, 13}; // 1-bit delay
    vecs[3] = '{2'b10, 5'd0,  32'h0000_0001, 32'h0000_0000, 6};  // 1-bit scan
    vecs[4] = '{2'b01, 5'd3,  32'h0000_0002, 32'h0000_0001, 10}; // IR <- BSR
    vecs[5] = '{2'b10, 5'd7,  32'h0000_005A, 32'h0000_00C3, 13}; // BSR capture
    vecs[6] = '{2'b00, 5'd9,  32'h1234_5678, 32'h0000_0000, 6};  // TAP reset
    vecs[7] = '{2'b10, 5'd15, 32'h0000_0000, 32'h0000_104D, 21}; // IDCODE restored
    vecs[8] = '{2'b11, 5'd5,  32'h0000_FFFF, 32'h0000_0000, 0};  // reserved
    vecs[9] = '{2'b01, 5'd3,  32'h0000_000F, 32'h0000_0001, 10}; // IR <- BYPASS

    // reset state and INIT sequence
    repeat (3) @(negedge CLK);
    check("reset_vals", {TCK, TMS, TDI, cmd_ready, rsp_valid, busy, rsp_data},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0});
    base = rise_cnt;
    RST_N = 1'b1;
    bad = 0;
    for (int k = 0; k < 48; k++) begin
      if (TCK !== ((k % 8) >= 4)) bad++;
      @(negedge CLK);
    end
    check("init_tck_wave", bad, 0);
    check("init_idle", {cmd_ready, busy, TCK}, 3'b100);
    check("init_tck_count", rise_cnt - base, 6);
    at = '0;
    for (int i = 0; i < 6; i++) at[i] = tms_hist[base + i];
    check("init_tms", at, 64'h1F);
    $display("[TB] init: %0d TCK pulses, cmd_ready=%0d", rise_cnt - base, cmd_ready);

    for (int i = 0; i < 10; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].t, vecs[i].len, vecs[i].d, vecs[i].rsp, vecs[i].per);

    // cmd_valid held with changing data: only the first command runs
    wait_ready("hold");
    base = rise_cnt;
    cmd_type = 2'b10;
    cmd_len = 5'd7;
    cmd_data = 32'h3C;
    cmd_valid = 1'b1;
    @(negedge CLK);
    cyc = 1;
    while (!rsp_valid && cyc < 2000) begin
      cmd_data = $urandom;
      @(negedge CLK);
      cyc++;
    end
    check("hold_rsp", rsp_data, 32'h78);
    check("hold_lat", cyc, 2 * CLK_DIV * 13 + 1);
    check("hold_tck", rise_cnt - base, 13);
    $display("[TB] hold first: rsp=%h latency=%0d clk", rsp_data, cyc);
    cmd_len = 5'd3;
    cmd_data = 32'hB;
    @(negedge CLK);
    check("hold_gap", {rsp_valid, cmd_ready}, 2'b01);
    @(negedge CLK);
    check("hold_accept2", {cmd_ready, busy}, 2'b01);
    cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
    end
    check("hold2_rsp", rsp_data, 32'h6);
    check("hold2_lat", cyc, 2 * CLK_DIV * 9 + 1);
    $display("[TB] hold second: rsp=%h latency=%0d clk", rsp_data, cyc);

    // reset asserted in the middle of a 32-bit shift
    wait_ready("midrst");
    base = rise_cnt;
    cmd_type = 2'b10;
    cmd_len = 5'd31;
    cmd_data = 32'hFFFF_FFFF;
    cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    cyc = 0;
    while ((rise_cnt - base < 10 || !TCK) && cyc < 1000) begin
      @(negedge CLK);
      cyc++;
    end
    check("midrst_reach", (rise_cnt - base >= 10) && TCK, 1);
    #2 RST_N = 1'b0;
    #1;
    check("midrst_outs", {TCK, TMS, TDI, cmd_ready, rsp_valid, busy, rsp_data},
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0});
    pulses = 0;
    repeat (10) begin
      @(negedge CLK);
      if (rsp_valid) pulses++;
    end
    base = rise_cnt;
    RST_N = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 500) begin
      @(negedge CLK);
      if (rsp_valid) pulses++;
      cyc++;
    end
    check("midrst_no_rsp", pulses, 0);
    check("reinit_tck", rise_cnt - base, 6);
    $display("[TB] reset mid-shift: reinit pulses=%0d", rise_cnt - base);
    run_cmd("idcode_after_rst", 2'b10, 5'd31, 32'h0, IDCODE_VAL, 37);

    check("tms_tdi_stable_tck_high", viol, 0);
    check("tck_high_phase", phase_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
